// File: rtl/dmem_rmw_ctrl.sv
// Data-memory access sequencer between the MEM stage and a single-port
// synchronous data RAM. Loads and word stores go straight through; byte and
// halfword stores read the word, let the external width converter merge the
// new data in, and write the merged word back. Misaligned requests complete
// with an error and never touch the RAM.
module dmem_rmw_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_width,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        conv_width,
    output logic [1:0]        conv_pos,
    output logic [31:0]       conv_rf_data,
    output logic [31:0]       conv_mem_data,
    input  logic [31:0]       conv_merged,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    // Width codes shared with the store-side converter; 2'b11 behaves as word.
    localparam logic [1:0] WCONV_WORD = 2'd0;
    localparam logic [1:0] WCONV_HALF = 2'd1;
    localparam logic [1:0] WCONV_BYTE = 2'd2;

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              we_q;
    logic [1:0]        width_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem_q;
    logic              err_q;

    logic              accept;
    logic              req_sub;
    logic              req_misaligned;
    logic              unused_addr_hi;

    // Upper byte-address bits lie outside the RAM and are ignored.
    assign unused_addr_hi = ^{req_addr[31:ADDR_W+2], WCONV_WORD};

    assign req_ready      = (state == IDLE) && !rst;
    assign accept         = req_valid && req_ready;
    assign req_sub        = (req_width == WCONV_HALF) || (req_width == WCONV_BYTE);
    assign req_misaligned = ((req_width == WCONV_HALF) && req_addr[0]) ||
                            (!req_sub && (req_addr[1:0] != 2'b00));

    // Outputs decode from registered state only, so reset drops them at once.
    assign ram_en        = (state == RD) || (state == WR);
    assign ram_we        = (state == WR);
    assign ram_addr      = addr_q[ADDR_W+1:2];
    assign ram_wdata     = conv_merged;
    assign resp_valid    = (state == DONE);
    assign resp_err      = (state == DONE) && err_q;
    assign resp_rdata    = mem_q;
    assign conv_width    = width_q;
    assign conv_pos      = addr_q[1:0];
    assign conv_rf_data  = wdata_q;
    assign conv_mem_data = mem_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: misaligned skips the RAM, word stores skip the read.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_misaligned) begin
                        state_nxt = DONE;
                    end else if (!req_we || req_sub) begin
                        state_nxt = RD;
                    end else begin
                        state_nxt = WR;
                    end
                end
            end
            RD:      state_nxt = CAP;
            CAP:     state_nxt = we_q ? WR : DONE;
            WR:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured once at accept and held for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            width_q <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= req_we;
            width_q <= req_width;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
        end
    end

    // RAM read data is registered in CAP; it is both load result and merge base.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= 32'h0;
        end else if (state == CAP) begin
            mem_q <= ram_rdata;
        end
    end

    // Error flag lives from accept until the DONE cycle reports it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= req_misaligned;
        end else if (state == DONE) begin
            err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl: RAM and width-converter models around the DUT,
// a reference memory model, and a scoreboard monitor on resp_valid.
module tb_dmem_rmw_ctrl;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_width = 2'd0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [1:0]        conv_width;
    logic [1:0]        conv_pos;
    logic [31:0]       conv_rf_data;
    logic [31:0]       conv_mem_data;
    logic [31:0]       conv_merged;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    dmem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .conv_width(conv_width), .conv_pos(conv_pos), .conv_rf_data(conv_rf_data),
        .conv_mem_data(conv_mem_data), .conv_merged(conv_merged),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM.
    logic [31:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram[ram_addr];
        end
    end

    // Store-side width converter, lane by lane.
    function automatic logic [31:0] conv_fn(input logic [1:0] w, input logic [1:0] p,
                                            input logic [31:0] rf, input logic [31:0] mem);
        case (w)
            2'd2: case (p)
                2'd0: return {mem[31:8], rf[7:0]};
                2'd1: return {mem[31:16], rf[7:0], mem[7:0]};
                2'd2: return {mem[31:24], rf[7:0], mem[15:0]};
                default: return {rf[7:0], mem[23:0]};
            endcase
            2'd1: return p[1] ? {rf[15:0], mem[15:0]} : {mem[31:16], rf[15:0]};
            default: return rf;
        endcase
    endfunction
    assign conv_merged = conv_fn(conv_width, conv_pos, conv_rf_data, conv_mem_data);

    typedef struct {
        logic        err;
        logic        is_load;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        int          idx;
        logic [31:0] word_after;
        int          acc_cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [0:15];
    int          checks = 0;
    int          errs = 0;
    int          issued = 0;
    int          resps = 0;
    bit          mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present a request and hold it until accepted; record the expected outcome.
    task automatic issue(input logic we, input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] d);
        int n;
        exp_t e;
        bit half, byt, mis;
        logic [31:0] mask;
        int sh;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_width = w; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errs++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1");
            req_valid = 1'b0;
            return;
        end
        half = (w == 2'd1);
        byt  = (w == 2'd2);
        mis  = (half && a[0]) || (!half && !byt && a[1:0] != 2'b00);
        e.err = mis; e.is_load = !we; e.idx = int'(a[5:2]);
        e.acc_cyc = cyc + 1;
        e.rdata = mdl[e.idx];
        if (mis) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (!we) begin
            e.lat = 3; e.nrd = 1; e.nwr = 0;
        end else if (half || byt) begin
            e.lat = 4; e.nrd = 1; e.nwr = 1;
            sh   = 8 * int'(a[1:0]);
            mask = (half ? 32'h0000FFFF : 32'h000000FF) << sh;
            mdl[e.idx] = (mdl[e.idx] & ~mask) | ((d << sh) & mask);
        end else begin
            e.lat = 2; e.nrd = 0; e.nwr = 1;
            mdl[e.idx] = d;
        end
        e.word_after = mdl[e.idx];
        q.push_back(e);
        issued++;
        @(posedge clk);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    // Monitor: count RAM cycles per transaction and score each response.
    initial begin
        int nrd = 0;
        int nwr = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ram_en && !ram_we) nrd++;
                if (ram_en && ram_we)  nwr++;
                if (resp_valid) begin
                    resps++;
                    if (q.size() == 0) begin
                        checks++; errs++;
                        $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
                    end else begin
                        e = q.pop_front();
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                        chk("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
                        chk("ram_reads", 32'(nrd), 32'(e.nrd));
                        chk("ram_writes", 32'(nwr), 32'(e.nwr));
                        if (e.is_load && !e.err) chk("resp_rdata", resp_rdata, e.rdata);
                        if (!e.is_load && !e.err) chk("ram_word", ram[e.idx], e.word_after);
                    end
                    nrd = 0;
                    nwr = 0;
                end
            end
        end
    end

    initial begin
        // Reset state.
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        // Reset in the middle of a read: access must be abandoned.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_width = 2'd0; req_addr = 32'h4;
        chk("pre_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rd_ram_en", 32'(ram_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ram_en", 32'(ram_en), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        mon_en = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
        end

        // Fill the reference region with word stores.
        for (int i = 0; i < 16; i++) issue(1'b1, 2'd0, 32'(i * 4), $urandom);
        drain();

        // Directed cases.
        issue(1'b1, 2'd0, 32'h4, 32'h11223344);
        issue(1'b0, 2'd0, 32'h4, 32'h0);
        issue(1'b1, 2'd2, 32'h6, 32'h000000AB);
        drain();
        chk("byte_store_word", ram[1], 32'h11AB3344);
        issue(1'b1, 2'd0, 32'h4, 32'h11223344);
        issue(1'b1, 2'd1, 32'h4, 32'h0000CDEF);
        drain();
        chk("half_store_word", ram[1], 32'h1122CDEF);
        issue(1'b0, 2'd1, 32'h4, 32'h0);
        issue(1'b1, 2'd0, 32'h8, 32'hDEADBEEF);
        drain();
        chk("word_store_word", ram[2], 32'hDEADBEEF);
        issue(1'b1, 2'd1, 32'h5, 32'h12345678);
        issue(1'b0, 2'd0, 32'h2, 32'h0);
        issue(1'b1, 2'd3, 32'h9, 32'h0);
        drain();

        // Randomized traffic, back-to-back or with idle gaps.
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  32'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drain();
        repeat (3) @(negedge clk);
        chk("resp_count", 32'(resps), 32'(issued));

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule

// File: doc/dmem_rmw_ctrl.md
# dmem_rmw_ctrl

Data-memory access sequencer between the MEM pipeline stage and a single-port synchronous data RAM. It handles loads and word stores directly. For byte and halfword stores it runs a read-modify-write: it reads the target word, presents it to the store-side width converter, and writes the merged word back. It stalls the pipeline through a ready/valid handshake and flags misaligned accesses without touching RAM.

## Interface
- ADDR_W, 10, RAM word-address width; the RAM holds 2^ADDR_W 32-bit words.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  memory request present.
- req_ready  out  1  block can accept a request; equals (state==IDLE) && !rst.
- req_we  in  1  1 = store, 0 = load.
- req_width  in  2  `WCONV_WORD / `WCONV_HALF / `WCONV_BYTE (codes from definition.vh).
- req_addr  in  32  byte address.
- req_wdata  in  32  register-file store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid only with resp_valid; 1 = misaligned request, dropped.
- resp_rdata  out  32  raw memory word for loads; load alignment is done downstream.
- conv_width  out  2  latched req_width, driven to the converter widthType.
- conv_pos  out  2  latched req_addr[1:0], driven to the converter dataPos.
- conv_rf_data  out  32  latched req_wdata, driven to the converter iRfData.
- conv_mem_data  out  32  captured RAM word, driven to the converter iMemData.
- conv_merged  in  32  converter oMemData.
- ram_en, ram_we  out  1  RAM enable and write enable.
- ram_addr  out  ADDR_W  word address = latched req_addr[ADDR_W+1:2].
- ram_wdata  out  32  equals conv_merged.
- ram_rdata  in  32  RAM read data, valid one cycle after a read-enable edge.

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE: on req_valid && req_ready, latch we, width, addr and wdata. Then check alignment:
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE with err_q=1. No RAM access.
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- RD: ram_en=1, ram_we=0. Next state CAP.
- CAP: mem_q <= ram_rdata. Load goes to DONE; sub-word store goes to WR.
- WR: ram_en=1, ram_we=1, ram_wdata=conv_merged. Next state DONE.
  - For word stores the converter passes conv_rf_data through, so mem_q is don't-care.
- DONE: resp_valid=1 and resp_err=err_q. Next state IDLE; err_q clears.
- resp_rdata = mem_q at all times.
- ram_en and ram_we decode combinationally from the state register only and are 0 in all other states.
- Unknown req_width codes are treated as word.
- Latched fields and mem_q hold their values outside the accept and CAP edges.

## Timing
- Accept edge = T. resp_valid is high in the cycle after:
  - load: edge T+3 (RD T+1, CAP T+2, DONE T+3).
  - byte/half store: edge T+4; the RAM write occurs at edge T+4.
  - word store: edge T+2; the RAM write occurs at edge T+2.
  - misaligned: edge T+1.
- Throughput: no accept in DONE. The next request is accepted at the earliest in the IDLE cycle following DONE.
- req_valid while req_ready=0 is ignored; the requester holds its request.
- Reset values: state=IDLE, latched fields=0, mem_q=0, err_q=0, resp_valid=0, resp_err=0, ram_en=0, ram_we=0, req_ready=0 while rst is high.
- Reset mid-operation: returns to IDLE immediately and drops the pending response. ram_we falls asynchronously, so a write coinciding with reset is not guaranteed to land.
- Back-to-back RMW to the same word: the second read sees the first write, because the write completes before DONE.

## Test plan
- Reset: assert rst mid-RD -> state IDLE, ram_en=0, no resp_valid; after release, req_ready=1.
- Load: RAM[1]=0x11223344, load at addr 0x4 -> resp_valid at T+3, resp_rdata=0x11223344, one RAM read, no write.
- Byte store: RAM[1]=0x11223344, byte store at addr 0x6 with wdata 0x000000AB -> ram_we pulse at T+4 with ram_wdata=0x11AB3344, resp_valid at T+4.
- Half store: RAM[1]=0x11223344, half store at addr 0x4 with wdata 0x0000CDEF -> RAM[1]=0x1122CDEF. A following load at addr 0x4 returns 0x1122CDEF.
- Word store: word store at addr 0x8 with 0xDEADBEEF -> no read cycle, write at T+2, RAM[2]=0xDEADBEEF.
- Misaligned: half store at addr 0x5 -> resp_valid=1 and resp_err=1 at T+1, no ram_en. Also check that req_valid held during busy states is accepted exactly once.
